// File: rtl/cart_mapper_pkg.sv
// Shared types and constants for the cartridge bank mapper.
package cart_mapper_pkg;

    typedef enum logic [1:0] {
        WT_OPEN       = 2'd0,
        WT_ROM_FIXED  = 2'd1,
        WT_ROM_BANKED = 2'd2,
        WT_RAM_BANKED = 2'd3
    } win_type_e;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ARMED    = 2'd1,
        LOCKED   = 2'd2
    } lock_state_e;

    localparam logic [7:0] LOCK_KEY1 = 8'h5A;
    localparam logic [7:0] LOCK_KEY2 = 8'hA5;
    localparam int         ROM_AW    = 25;

    function automatic logic is_rom(input win_type_e t);
        return (t == WT_ROM_FIXED) || (t == WT_ROM_BANKED);
    endfunction

endpackage

// File: rtl/cart_bank_lock.sv
// Lock FSM: two-key write sequence freezes the bank registers until reset.
// State updates on the clk_sys edge of a qualified lock-register write.
module cart_bank_lock
    import cart_mapper_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        wr_stb_i,
    input  logic [7:0]  din_i,
    output lock_state_e state_o
);

    lock_state_e state_q, state_d;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UNLOCKED: if (wr_stb_i && din_i == LOCK_KEY1) state_d = ARMED;
            // Any wrong second key drops back so a stray write cannot half-arm the lock.
            ARMED:    if (wr_stb_i) state_d = (din_i == LOCK_KEY2) ? LOCKED : UNLOCKED;
            LOCKED:   state_d = LOCKED;
            default:  state_d = UNLOCKED;
        endcase
    end

    always_comb begin
        state_o = state_q;
    end

endmodule

// File: rtl/cart_mapper_gen.sv
// Windowed cartridge bank mapper with hotspot bank writes and a lock FSM.
// Optional bank/lock readback on hotspot reads when CART_MAPPER_READBACK_EN is defined.
module cart_mapper_gen
    import cart_mapper_pkg::*;
#(
    parameter int          WIN_BITS = 3,
    parameter int          BANK_W   = 8,
    parameter int          RAM_AW   = 17,
    parameter logic [15:0] HOT_BASE = 16'hFF80
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic                         pclk0,
    input  logic                         pclk1,
    input  logic [15:0]                  address_in,
    input  logic [7:0]                   din,
    input  logic                         rw,
    input  logic                         cart_cs,
    input  logic [2*(2**WIN_BITS)-1:0]   win_type,
    input  logic [BANK_W*(2**WIN_BITS)-1:0] win_bank_init,
    input  logic [BANK_W-1:0]            bank_mask,
    input  logic [7:0]                   rom_din,
    input  logic [7:0]                   ram_din,
    input  logic [7:0]                   open_bus,
    output logic [ROM_AW-1:0]            rom_address,
    output logic [RAM_AW-1:0]            ram_address,
    output logic                         ram_cs,
    output logic                         ram_we,
    output logic [7:0]                   dout,
    output logic                         cart_read,
    output logic                         locked
);

    localparam int          WIN_COUNT = 2**WIN_BITS;
    localparam int          OFF_W     = 16 - WIN_BITS;
    localparam int          FULL_W    = BANK_W + OFF_W;
    localparam logic [15:0] LOCK_ADDR = HOT_BASE + 16'(WIN_COUNT);

    logic [WIN_BITS-1:0] idx;
    logic [OFF_W-1:0]    offset;
    win_type_e           wtype;
    logic [BANK_W-1:0]   bank_q   [WIN_COUNT];
    logic [BANK_W-1:0]   bank_d   [WIN_COUNT];
    logic [BANK_W-1:0]   bank_eff [WIN_COUNT];
    logic [FULL_W-1:0]   full_addr;

    logic [15:0]         hot_off;
    logic                hot_hit;
    logic [WIN_BITS-1:0] hot_idx;
    logic                lock_hit;
    logic                wr_stb;
    logic                capture;

    logic                pend_vld_q, pend_vld_d;
    logic [WIN_BITS-1:0] pend_idx_q, pend_idx_d;
    logic [BANK_W-1:0]   pend_dat_q, pend_dat_d;
    win_type_e           commit_type;
    logic                commit;
    logic                commit_wr;
    logic                cart_read_q, cart_read_d;
    lock_state_e         lock_state;

    assign idx    = address_in[15 -: WIN_BITS];
    assign offset = address_in[OFF_W-1:0];
    assign wtype  = win_type_e'(win_type[{idx, 1'b0} +: 2]);

    // During reset the translation already uses the init banks, not the stale registers.
    always_comb begin
        for (int i = 0; i < WIN_COUNT; i++) begin
            bank_eff[i] = reset ? win_bank_init[i*BANK_W +: BANK_W] : bank_q[i];
        end
    end

    assign full_addr = {bank_eff[idx] & bank_mask, offset};

    assign hot_off  = address_in - HOT_BASE;
    assign hot_hit  = hot_off < 16'(WIN_COUNT);
    assign hot_idx  = hot_off[WIN_BITS-1:0];
    assign lock_hit = (address_in == LOCK_ADDR);
    assign wr_stb   = pclk0 & cart_cs & ~rw;
    assign locked   = (lock_state == LOCKED);
    assign capture  = wr_stb & hot_hit & ~locked;

    // A capture that lands on an uncommitted write flushes the older one first.
    assign commit      = pend_vld_q & (pclk1 | capture);
    assign commit_type = win_type_e'(win_type[{pend_idx_q, 1'b0} +: 2]);
    assign commit_wr   = commit & (commit_type != WT_ROM_FIXED);

    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_idx_d = pend_idx_q;
        pend_dat_d = pend_dat_q;
        if (commit) begin
            pend_vld_d = 1'b0;
        end
        if (capture) begin
            pend_vld_d = 1'b1;
            pend_idx_d = hot_idx;
            pend_dat_d = BANK_W'(din);
        end
    end

    always_comb begin
        for (int i = 0; i < WIN_COUNT; i++) begin
            bank_d[i] = bank_q[i];
        end
        if (commit_wr) begin
            bank_d[pend_idx_q] = pend_dat_q;
        end
    end

    assign cart_read_d = rw & cart_cs;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pend_vld_q  <= 1'b0;
            pend_idx_q  <= '0;
            pend_dat_q  <= '0;
            cart_read_q <= 1'b0;
            for (int i = 0; i < WIN_COUNT; i++) begin
                bank_q[i] <= win_bank_init[i*BANK_W +: BANK_W];
            end
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_idx_q  <= pend_idx_d;
            pend_dat_q  <= pend_dat_d;
            cart_read_q <= cart_read_d;
            bank_q      <= bank_d;
        end
    end

    assign cart_read = cart_read_q;

    cart_bank_lock u_lock (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .wr_stb_i (wr_stb & lock_hit),
        .din_i    (din),
        .state_o  (lock_state)
    );

    always_comb begin
        rom_address = '0;
        ram_address = '0;
        ram_cs      = 1'b0;
        dout        = open_bus;
        if (is_rom(wtype)) begin
            dout = rom_din;
            if (cart_cs) rom_address = ROM_AW'(full_addr);
        end else if (wtype == WT_RAM_BANKED) begin
            dout = ram_din;
            if (cart_cs) begin
                ram_cs      = 1'b1;
                ram_address = RAM_AW'(full_addr);
            end
        end
`ifdef CART_MAPPER_READBACK_EN
        if (cart_cs && rw) begin
            if (hot_hit) begin
                dout = 8'(bank_eff[hot_idx]);
            end else if (lock_hit) begin
                dout = {6'b0, lock_state};
            end
        end
`else
`endif
    end

    assign ram_we = ram_cs & ~rw & pclk0;

endmodule

// File: tb/tb_cart_mapper_gen.sv
// Directed bench for cart_mapper_gen: translation table plus bank-write, lock and reset sequences.
module tb_cart_mapper_gen;

    logic        clk_sys = 1'b0;
    logic        reset, pclk0, pclk1, rw, cart_cs;
    logic [15:0] address_in;
    logic [7:0]  din, rom_din, ram_din, open_bus, bank_mask, dout;
    logic [15:0] win_type;
    logic [63:0] win_bank_init;
    logic [24:0] rom_address;
    logic [16:0] ram_address;
    logic        ram_cs, ram_we, cart_read, locked;

    int pass_cnt = 0;
    int tot_cnt  = 0;

`ifdef CART_MAPPER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    typedef struct {
        logic [15:0] addr;
        logic        cs;
        logic [24:0] rom;
        logic [16:0] ram;
        logic        ramcs;
        logic [7:0]  dout;
    } vec_t;

    vec_t vecs [8];

    always #5 clk_sys = ~clk_sys;

    cart_mapper_gen dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .pclk0         (pclk0),
        .pclk1         (pclk1),
        .address_in    (address_in),
        .din           (din),
        .rw            (rw),
        .cart_cs       (cart_cs),
        .win_type      (win_type),
        .win_bank_init (win_bank_init),
        .bank_mask     (bank_mask),
        .rom_din       (rom_din),
        .ram_din       (ram_din),
        .open_bus      (open_bus),
        .rom_address   (rom_address),
        .ram_address   (ram_address),
        .ram_cs        (ram_cs),
        .ram_we        (ram_we),
        .dout          (dout),
        .cart_read     (cart_read),
        .locked        (locked)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic hot_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        address_in = a; din = d; rw = 1'b0; cart_cs = 1'b1; pclk0 = 1'b1;
        @(negedge clk_sys);
        pclk0 = 1'b0; rw = 1'b1; cart_cs = 1'b0;
    endtask

    task automatic do_pclk1();
        @(negedge clk_sys);
        pclk1 = 1'b1;
        @(negedge clk_sys);
        pclk1 = 1'b0;
    endtask

    task automatic drive_rd(input logic [15:0] a);
        @(negedge clk_sys);
        address_in = a; rw = 1'b1; cart_cs = 1'b1; pclk0 = 1'b0;
        #1;
    endtask

    initial begin
        // w7..w0 types: 1,2,2,2,2,3,1,0 ; banks: 7,6,5,3,3,1,1,0
        win_type      = {2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
        win_bank_init = {8'd7, 8'd6, 8'd5, 8'd3, 8'd3, 8'd1, 8'd1, 8'd0};
        bank_mask = 8'h0F;
        rom_din = 8'hC3; ram_din = 8'h3C; open_bus = 8'hEE;
        reset = 1'b1; pclk0 = 1'b0; pclk1 = 1'b0; rw = 1'b1; cart_cs = 1'b0;
        address_in = 16'h0000; din = 8'h00;

        vecs[0] = '{16'h8123, 1'b1, 25'h006123, 17'h00000, 1'b0, 8'hC3};
        vecs[1] = '{16'h4010, 1'b1, 25'h000000, 17'h02010, 1'b1, 8'h3C};
        vecs[2] = '{16'h0100, 1'b1, 25'h000000, 17'h00000, 1'b0, 8'hEE};
        vecs[3] = '{16'h2005, 1'b1, 25'h002005, 17'h00000, 1'b0, 8'hC3};
        vecs[4] = '{16'h8123, 1'b0, 25'h000000, 17'h00000, 1'b0, 8'hC3};
        vecs[5] = '{16'hBFFF, 1'b1, 25'h00BFFF, 17'h00000, 1'b0, 8'hC3};
        vecs[6] = '{16'h5FFF, 1'b1, 25'h000000, 17'h03FFF, 1'b1, 8'h3C};
        vecs[7] = '{16'hFF84, 1'b1, 25'h00FF84, 17'h00000, 1'b0, RB ? 8'h03 : 8'hC3};

        @(negedge clk_sys);
        @(negedge clk_sys);
        check("rst_locked", locked, 0);
        check("rst_cart_read", cart_read, 0);
        reset = 1'b0;

        for (int k = 0; k < 8; k++) begin
            @(negedge clk_sys);
            if (k > 0) check($sformatf("cart_read_v%0d", k - 1), cart_read, vecs[k-1].cs);
            address_in = vecs[k].addr; cart_cs = vecs[k].cs; rw = 1'b1;
            #1;
            check($sformatf("rom_v%0d", k), rom_address, vecs[k].rom);
            check($sformatf("ram_v%0d", k), ram_address, vecs[k].ram);
            check($sformatf("ramcs_v%0d", k), ram_cs, vecs[k].ramcs);
            check($sformatf("ramwe_v%0d", k), ram_we, 0);
            check($sformatf("dout_v%0d", k), dout, vecs[k].dout);
        end

        // Bank write commits only at pclk1
        hot_write(16'hFF84, 8'h05);
        drive_rd(16'h8123); check("pre_commit", rom_address, 25'h006123);
        do_pclk1();
        drive_rd(16'h8123); check("post_commit", rom_address, 25'h00A123);
        drive_rd(16'hFF84); check("readback_bank", dout, RB ? 8'h05 : 8'hC3);

        hot_write(16'hFF84, 8'h15);
        do_pclk1();
        drive_rd(16'h8123); check("mask_wrap", rom_address, 25'h00A123);

        // RAM write strobe
        @(negedge clk_sys);
        address_in = 16'h4010; din = 8'h33; rw = 1'b0; cart_cs = 1'b1; pclk0 = 1'b0;
        #1;
        check("ram_addr_wr", ram_address, 17'h02010);
        check("ramwe_before", ram_we, 0);
        @(negedge clk_sys);
        pclk0 = 1'b1; #1;
        check("ramwe_pclk0", ram_we, 1);
        @(negedge clk_sys);
        pclk0 = 1'b0; #1;
        check("ramwe_after", ram_we, 0);
        check("cart_read_wr", cart_read, 0);
        rw = 1'b1; cart_cs = 1'b0;

        // Back-to-back captures without pclk1
        hot_write(16'hFF83, 8'h02);
        hot_write(16'hFF85, 8'h06);
        drive_rd(16'h6000); check("older_commit", rom_address, 25'h004000);
        drive_rd(16'hA000); check("newer_pending", rom_address, 25'h00A000);
        do_pclk1();
        drive_rd(16'hA000); check("newer_commit", rom_address, 25'h00C000);

        hot_write(16'hFF81, 8'h09);
        do_pclk1();
        drive_rd(16'h2005); check("fixed_discard", rom_address, 25'h002005);

        // Lock sequences
        hot_write(16'hFF88, 8'h5A);
        hot_write(16'hFF88, 8'h00);
        hot_write(16'hFF88, 8'hA5);
        check("wrong_key_unlocked", locked, 0);
        hot_write(16'hFF88, 8'h5A);
        check("armed_not_locked", locked, 0);
        hot_write(16'hFF86, 8'h02);
        hot_write(16'hFF88, 8'hA5);
        check("locked", locked, 1);
        drive_rd(16'hFF88); check("readback_lock", dout, RB ? 8'h02 : 8'hC3);
        do_pclk1();
        drive_rd(16'hC000); check("pending_survives_lock", rom_address, 25'h004000);
        hot_write(16'hFF84, 8'h07);
        do_pclk1();
        drive_rd(16'h8123); check("locked_ignores", rom_address, 25'h00A123);

        // Reset clears lock and any uncommitted write
        @(negedge clk_sys); reset = 1'b1;
        @(negedge clk_sys); reset = 1'b0;
        check("reset_unlocks", locked, 0);
        hot_write(16'hFF84, 8'h09);
        @(negedge clk_sys);
        reset = 1'b1; address_in = 16'h8123; rw = 1'b1; cart_cs = 1'b1;
        #1;
        check("reset_comb_bank", rom_address, 25'h006123);
        @(negedge clk_sys); reset = 1'b0;
        do_pclk1();
        drive_rd(16'h8123); check("reset_drops_pending", rom_address, 25'h006123);
        check("reset_locked_low", locked, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/cart_mapper_gen.md
CART_MAPPER_GEN -- requirements
Module: cart_mapper_gen

Interface
REQ-001 SHALL have parameter WIN_BITS, default 3: log2 of the window count; WIN_COUNT = 2**WIN_BITS; window size 2**(16-WIN_BITS) bytes.
REQ-002 SHALL have parameter BANK_W, default 8: width of each bank register.
REQ-003 SHALL have parameter RAM_AW, default 17: width of the cart RAM address.
REQ-004 SHALL have parameter HOT_BASE, default 16'hFF80: base address of the bank hotspots; the lock register is at HOT_BASE+WIN_COUNT.
REQ-005 clk_sys  in  1  system clock.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 pclk0, pclk1  in  1 each  CPU phase enables, one clk_sys wide, mutually exclusive.
REQ-008 address_in  in  16, din  in  8, rw  in  1 (write low), cart_cs  in  1  CPU bus.
REQ-009 win_type  in  2*WIN_COUNT  per-window type: 0 open, 1 fixed ROM, 2 banked ROM, 3 banked RAM.
REQ-010 win_bank_init  in  BANK_W*WIN_COUNT  per-window bank value loaded at reset.
REQ-011 bank_mask  in  BANK_W  AND-mask applied to every bank before address formation.
REQ-012 rom_din  in  8, ram_din  in  8, open_bus  in  8  read sources.
REQ-013 rom_address  out  25, ram_address  out  RAM_AW, ram_cs  out  1, ram_we  out  1.
REQ-014 dout  out  8, cart_read  out  1 (registered rw&&cart_cs), locked  out  1.

Function
REQ-015 Window index SHALL be idx = address_in[15:16-WIN_BITS]; offset SHALL be address_in[15-WIN_BITS:0].
REQ-016 rom_address SHALL be zero-extended {bank[idx]&bank_mask, offset}, combinational, when win_type[idx] is 1 or 2 and cart_cs is high; otherwise 0.
REQ-017 When win_type[idx]==3 and cart_cs is high: ram_cs SHALL be 1; ram_address SHALL be {bank[idx]&bank_mask, offset} truncated to the low RAM_AW bits.
REQ-018 ram_we SHALL equal ram_cs & ~rw & pclk0.
REQ-019 dout SHALL select open_bus (type 0), rom_din (types 1 and 2), or ram_din (type 3).
REQ-020 Hotspot write: a write at pclk0 with cart_cs, ~rw, and address_in == HOT_BASE+i (i<WIN_COUNT) SHALL capture (i, din) into a pending register while the FSM is not LOCKED.
REQ-021 A pending write SHALL commit to bank[i] on the next pclk1. Accesses before that commit SHALL use the old bank.
REQ-022 A pending write to a type-1 window SHALL be discarded.
REQ-023 If a new capture coincides with an uncommitted pending write, the older write SHALL commit in the same clk_sys and the new one SHALL become pending.
REQ-024 Lock FSM states SHALL be UNLOCKED, ARMED, LOCKED, qualified by pclk0 writes to HOT_BASE+WIN_COUNT:
- UNLOCKED, write 0x5A -> ARMED.
- ARMED, write 0xA5 -> LOCKED; ARMED, any other value -> UNLOCKED.
- LOCKED is held until reset.
REQ-025 locked SHALL be 1 only in LOCKED. A hotspot write in LOCKED SHALL be ignored; a write already pending on entry to LOCKED SHALL still commit.
REQ-026 Bank values above bank_mask SHALL wrap via the mask; no error is raised.

Reset
REQ-027 On reset, bank[i] SHALL load win_bank_init[i]; the pending register SHALL clear, including any write that has not yet committed.
REQ-028 On reset, the FSM SHALL go to UNLOCKED, and locked and cart_read SHALL go to 0.
REQ-029 The combinational outputs (rom_address, ram_*, dout) SHALL follow the reset bank values in the same cycle.

Configuration
REQ-030 With CART_MAPPER_READBACK_EN defined, a read of HOT_BASE+i SHALL return bank[i] zero-extended or truncated to 8 bits, and a read of the lock address SHALL return {6'b0, FSM state}.
REQ-031 Without CART_MAPPER_READBACK_EN, hotspot and lock reads SHALL return the normal window data per REQ-019.

Structure
REQ-032 A shared package cart_mapper_pkg SHALL hold the window-type enum, the lock-FSM state enum, and the constants LOCK_KEY1=8'h5A and LOCK_KEY2=8'hA5.
REQ-033 One sub-module, cart_bank_lock, SHALL implement the lock FSM. Bank registers and translation SHALL stay in the top level.

Verification (WIN_BITS=3, bank_mask=8'h0F, window 4 type 2, window 2 type 3 with init 1)
REQ-034 Write 0xFF84<-0x05, then read 0x8123 after pclk1 -> rom_address=25'h00A123; a read before that pclk1 uses init bank.
REQ-035 Write 0xFF84<-0x15 -> read 0x8123 gives rom_address=25'h00A123 (mask wrap).
REQ-036 Write 0x4010<-0x33 -> ram_address=17'h02010; ram_we high for exactly the pclk0 cycle.
REQ-037 Write 0xFF88<-0x5A, then 0xA5 -> locked=1; subsequent 0xFF84<-0x07 is ignored and the bank stays 5. A sequence of 0x5A then 0x00 returns to UNLOCKED.
REQ-038 Hotspot write at pclk0, then reset before pclk1 -> bank[4] equals win_bank_init[4] and locked=0.
REQ-039 With CART_MAPPER_READBACK_EN, a read of 0xFF84 after writing 0x05 -> dout=0x05. Without the macro, the same read -> dout=rom_din.
